// File: rtl/neuron_input_feeder.sv
// Streams (value, weight) pairs into the packed calculator buses, runs the calculator
// for its full latency, then holds the captured result until downstream accepts it.
module neuron_input_feeder #(
  parameter int N     = 784,
  parameter int W     = 16,
  parameter int LAT   = 11,
  parameter int CNT_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_value,
  input  logic [W-1:0]   in_weight,
  input  logic           in_last,
  output logic [N*W-1:0] values,
  output logic [N*W-1:0] weights,
  output logic           calc_en,
  input  logic [15:0]    calc_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [15:0]    res_data,
  output logic           short_frm,
  output logic           busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, RESULT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx;
  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             last_slot;
  logic             cnt_done;
  logic             handoff;

  assign xfer      = in_valid && (state == LOAD);
  assign last_slot = (idx == CNT_W'(N - 1));
  assign cnt_done  = (cnt == CW'(LAT));
  assign handoff   = (state == RESULT) && res_ready;

  assign in_ready  = (state == LOAD);
  assign calc_en   = (state == COMPUTE);
  assign res_valid = (state == RESULT);
  assign busy      = (state != LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (xfer && (last_slot || in_last)) state_nx = COMPUTE;
      COMPUTE: if (cnt_done) state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Slots beyond a short frame stay zero so they add nothing to the dot product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      values  <= '0;
      weights <= '0;
      idx     <= '0;
    end else if (xfer) begin
      values[idx*W +: W]  <= in_value;
      weights[idx*W +: W] <= in_weight;
      idx                 <= idx + CNT_W'(1);
    end else if (handoff) begin
      values  <= '0;
      weights <= '0;
      idx     <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      res_data  <= '0;
      short_frm <= 1'b0;
    end else begin
      short_frm <= xfer && in_last && !last_slot;
      if (state == COMPUTE && !cnt_done) cnt <= cnt + CW'(1);
      else                               cnt <= '0;
      if (state == COMPUTE && cnt_done) res_data <= calc_out;
    end
  end

endmodule

// File: tb/tb_neuron_input_feeder.sv
// Directed bench for neuron_input_feeder with a behavioural latency-LAT calculator
// that computes the dot product from the packed buses.
module tb_neuron_input_feeder;

  localparam int N   = 784;
  localparam int W   = 16;
  localparam int LAT = 11;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_value;
  logic [W-1:0]   in_weight;
  logic           in_last;
  logic [N*W-1:0] values;
  logic [N*W-1:0] weights;
  logic           calc_en;
  logic [15:0]    calc_out;
  logic           res_valid;
  logic           res_ready;
  logic [15:0]    res_data;
  logic           short_frm;
  logic           busy;

  int checks;
  int failures;

  logic [15:0] fr_val [N];
  logic [15:0] fr_wgt [N];

  neuron_input_feeder #(.N(N), .W(W), .LAT(LAT), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_weight(in_weight), .in_last(in_last),
    .values(values), .weights(weights), .calc_en(calc_en), .calc_out(calc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .short_frm(short_frm), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator stand-in: result is only valid after LAT enabled edges, garbage before.
  logic [3:0]  cal_cnt;
  logic [31:0] cal_sum;

  function automatic logic [31:0] busSum();
    int s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += int'($signed(values[k*W +: W])) * int'($signed(weights[k*W +: W]));
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cal_cnt <= '0;
      cal_sum <= '0;
    end else if (calc_en) begin
      if (cal_cnt == 0) cal_sum <= busSum();
      cal_cnt <= cal_cnt + 4'd1;
    end else begin
      cal_cnt <= '0;
    end
  end

  assign calc_out = (calc_en && cal_cnt >= 4'(LAT)) ? cal_sum[31:16] : 16'hDEAD;

  typedef struct packed {
    logic [2:0]       len;
    logic [3:0][15:0] v;
    logic [3:0][15:0] w;
    logic [15:0]      exp_res;
    logic             exp_short;
  } vec_t;

  vec_t tbl [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] modelResult(input int len);
    int s;
    s = 0;
    for (int k = 0; k < len; k++)
      s += int'($signed(fr_val[k])) * int'($signed(fr_wgt[k]));
    return s[31:16];
  endfunction

  task automatic applyStimulus(input int len, input int idle_pct, input bit send_last);
    int not_ready;
    not_ready = 0;
    for (int i = 0; i < len; i++) begin
      while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_value  = fr_val[i];
      in_weight = fr_wgt[i];
      in_last   = send_last && (i == len - 1);
      if (!in_ready) not_ready++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("in_ready_during_load", not_ready, 0);
  endtask

  task automatic checkSlots(input string name, input int len);
    logic [N*W-1:0] ev, ew;
    ev = '0;
    ew = '0;
    for (int k = 0; k < len; k++) begin
      ev[k*W +: W] = fr_val[k];
      ew[k*W +: W] = fr_wgt[k];
    end
    checkOutput({name, "_values_ok"}, 32'(values == ev), 1);
    checkOutput({name, "_weights_ok"}, 32'(weights == ew), 1);
  endtask

  task automatic waitResult(input string name, input logic exp_short);
    int cycles, en_cnt, short_cnt, rdy_cnt;
    cycles = 0; en_cnt = 0; short_cnt = 0; rdy_cnt = 0;
    while (!res_valid && cycles < 50) begin
      if (calc_en) en_cnt++;
      if (short_frm) short_cnt++;
      if (in_ready) rdy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, "_res_valid"}, 32'(res_valid), 1);
    checkOutput({name, "_calc_en_cycles"}, en_cnt, LAT + 1);
    checkOutput({name, "_short_pulses"}, short_cnt, 32'(exp_short));
    checkOutput({name, "_in_ready_compute"}, rdy_cnt, 0);
    checkOutput({name, "_busy_result"}, 32'(busy), 1);
  endtask

  task automatic handoff(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput({name, "_in_ready_after"}, 32'(in_ready), 1);
    checkOutput({name, "_res_valid_after"}, 32'(res_valid), 0);
    checkOutput({name, "_slots_cleared"}, 32'(values == '0 && weights == '0), 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; in_valid = 1'b0; in_value = '0; in_weight = '0; in_last = 1'b0;
    res_ready = 1'b0;

    tbl[0] = '{3'd3, {16'h0000, 16'hFF00, 16'h0100, 16'h0200},
                     {16'h0000, 16'h0100, 16'h0100, 16'h0100}, 16'h0002, 1'b1};
    tbl[1] = '{3'd1, {16'h0000, 16'h0000, 16'h0000, 16'h0300},
                     {16'h0000, 16'h0000, 16'h0000, 16'h0200}, 16'h0006, 1'b1};
    tbl[2] = '{3'd2, {16'h0000, 16'h0000, 16'hFE00, 16'h0080},
                     {16'h0000, 16'h0000, 16'h0100, 16'h0400}, 16'h0000, 1'b1};
    tbl[3] = '{3'd4, {16'h0040, 16'h0000, 16'h0100, 16'h0100},
                     {16'h0100, 16'h7FFF, 16'hFF00, 16'hFF00}, 16'hFFFE, 1'b1};

    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    checkOutput("reset_calc_en", 32'(calc_en), 0);
    checkOutput("reset_res_valid", 32'(res_valid), 0);
    checkOutput("reset_res_data", 32'(res_data), 0);
    checkOutput("reset_short_frm", 32'(short_frm), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of loading discards the partial frame.
    for (int k = 0; k < N; k++) begin
      fr_val[k] = 16'(k + 1);
      fr_wgt[k] = 16'(k + 7);
    end
    applyStimulus(100, 0, 1'b0);
    checkSlots("partial_load", 100);
    #2 reset = 1'b0;
    #1;
    checkOutput("midload_in_ready", 32'(in_ready), 1);
    checkOutput("midload_slots_zero", 32'(values == '0 && weights == '0), 1);
    checkOutput("midload_res_valid", 32'(res_valid), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Short frames from the table; each also checks the slot index restarted at 0.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++) begin fr_val[k] = '0; fr_wgt[k] = '0; end
      for (int k = 0; k < int'(tbl[t].len); k++) begin
        fr_val[k] = tbl[t].v[k];
        fr_wgt[k] = tbl[t].w[k];
      end
      applyStimulus(int'(tbl[t].len), 0, 1'b1);
      checkSlots($sformatf("vec%0d", t), int'(tbl[t].len));
      waitResult($sformatf("vec%0d", t), tbl[t].exp_short);
      checkOutput($sformatf("vec%0d_res_data", t), 32'(res_data), 32'(tbl[t].exp_res));
      handoff($sformatf("vec%0d", t));
    end

    // Full frame of 1.0*1.0 with res_ready held high throughout.
    for (int k = 0; k < N; k++) begin fr_val[k] = 16'h0100; fr_wgt[k] = 16'h0100; end
    res_ready = 1'b1;
    applyStimulus(N, 0, 1'b1);
    checkOutput("full_in_ready_drop", 32'(in_ready), 0);
    checkSlots("full", N);
    waitResult("full", 1'b0);
    checkOutput("full_res_data", 32'(res_data), 32'h0310);
    handoff("full");

    // Random full frame with idle gaps, then result held off for 20 cycles.
    for (int k = 0; k < N; k++) begin
      fr_val[k] = 16'($urandom_range(16'hFFFF));
      fr_wgt[k] = 16'($urandom_range(16'hFFFF));
    end
    applyStimulus(N, 30, 1'b0);
    checkSlots("rand", N);
    waitResult("rand", 1'b0);
    checkOutput("rand_res_data", 32'(res_data), 32'(modelResult(N)));
    begin
      int bad;
      logic [N*W-1:0] held;
      bad = 0;
      held = values;
      in_valid = 1'b1; in_value = 16'h1234; in_weight = 16'h5678;
      repeat (20) begin
        @(posedge clk); #1;
        if (!res_valid || res_data !== modelResult(N) || in_ready || values != held) bad++;
      end
      in_valid = 1'b0;
      checkOutput("hold_result_stable", bad, 0);
    end
    handoff("rand");

    // Reset during COMPUTE cycle 5 kills the run immediately.
    for (int k = 0; k < 3; k++) begin fr_val[k] = 16'h0100; fr_wgt[k] = 16'h0200; end
    applyStimulus(3, 0, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("pre_reset_calc_en", 32'(calc_en), 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_calc_en", 32'(calc_en), 0);
    checkOutput("abort_res_valid", 32'(res_valid), 0);
    @(negedge clk); reset = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (res_valid || calc_en) seen++;
      end
      checkOutput("abort_no_result", seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
